axi_h2c_read: RTL and testbench
===============================

# axi_h2c_read

Host-to-card AXI4-Stream receiver for the XDMA H2C channel. It accepts a packet of BEATS 512-bit beats from the XDMA H2C stream and assembles them, first beat in the least-significant slice, into one wide word. It then presents that word to user logic through a data_valid/data_next handshake. This is the return path for the C2H serializer and uses the same beat ordering, so a packet looped host→card→host is bit-identical.

## Interface
Parameters
- BEATS, 8, beats per packet; legal range 2..31.
- DW, 512, stream data width; fixed at 512.

Ports
- m_axis_h2c_aclk  in  1  sole clock.
- m_axis_h2c_areset  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous soft clear, active-high.
- m_axis_h2c_tdata  in  512  stream beat data.
- m_axis_h2c_tkeep  in  64  byte enables; all-ones expected.
- m_axis_h2c_tlast  in  1  last beat of packet.
- m_axis_h2c_tvalid  in  1  beat valid.
- m_axis_h2c_tready  out  1  beat accept.
- data  out  BEATS*512  assembled packet; beat k is at [k*512 +: 512].
- data_valid  out  1  assembled packet available.
- data_next  in  1  consumer accepts packet when high with data_valid.
- rstate  out  2  current FSM state, for debug.
- beat_cnt  out  5  beats accepted in the current packet.
- pkt_cnt  out  16  packets delivered, wraps at 2^16.
- err_len  out  1  sticky; tlast position did not match BEATS.
- err_keep  out  1  sticky; an accepted beat had tkeep ≠ 64'hFFFF_FFFF_FFFF_FFFF.

## Operation
- Beat accept is tvalid & tready.
- All outputs are registered. tready is decoded from the state register only.
- The FSM has three states:
  - COLLECT (0)
    - tready=1.
    - Each accepted beat writes data[beat_cnt*512 +: 512] and increments beat_cnt.
    - Correct packet end (beat_cnt==BEATS-1 with tlast=1): go to HOLD, set data_valid=1, clear beat_cnt.
    - Missing tlast (beat_cnt==BEATS-1 with tlast=0): set err_len, clear beat_cnt, go to DRAIN.
    - Early tlast (beat_cnt<BEATS-1 with tlast=1): set err_len, clear beat_cnt, stay in COLLECT. The partial packet is discarded and data_valid is not raised.
  - HOLD (1)
    - tready=0; data_valid=1; data is held stable.
    - On data_next: clear data_valid, increment pkt_cnt, go to COLLECT.
  - DRAIN (2)
    - tready=1; accepted beats are discarded and data is not written.
    - On an accepted beat with tlast=1: go to COLLECT.
- err_keep is set by any beat accepted in COLLECT or DRAIN with tkeep not all ones. In COLLECT the beat is still stored.
- err_len and err_keep clear only on reset or clr.
- clr has priority over every other event:
  - next state is COLLECT;
  - beat_cnt, data, data_valid, pkt_cnt, err_len and err_keep are cleared;
  - a beat accepted in the same cycle is dropped.
- data_next while data_valid=0 is ignored.

## Timing
- Reset values: tready=0 while reset is asserted, then 1 (COLLECT). data=0, data_valid=0, rstate=0, beat_cnt=0, pkt_cnt=0, err_len=0, err_keep=0.
- Reset is asynchronous: asserting it mid-packet forces all registers to their reset values immediately. The partial packet is lost.
- Latency: data_valid rises on the clock edge that accepts the final beat, so it is visible the next cycle. tready falls in that same cycle.
- Handshake: data_valid & data_next at edge N gives data_valid=0 and tready=1 after edge N. A beat can then be accepted at edge N+1.
- Throughput: a packet occupies at least BEATS+1 cycles, or BEATS+2 when data_next is answered one cycle late.
- tvalid gaps in COLLECT or DRAIN only stall the FSM; no timeout.
- pkt_cnt wraps from 16'hFFFF to 0.

## Test plan
- Nominal packet (BEATS=8, tvalid held high):
  - Stimulus: beats with tdata={64{8'hk}} for k=0..7, tlast on beat 7.
  - Response: data_valid=1 one cycle after beat 7; data[k*512 +: 512]=={64{8'hk}}; tready=0 during HOLD.
  - Then pulse data_next. Response: pkt_cnt=1, tready=1 next cycle.
- Backpressure, with data_next held low 20 cycles: tvalid during HOLD is not accepted and data is stable throughout. A following packet is assembled correctly after data_next.
- Early tlast on beat 3:
  - Response: err_len=1, no data_valid, beat_cnt=0.
  - Then send a full packet of value 8'hA5. Response: delivered correctly, pkt_cnt=1.
- Missing tlast, with tlast first on beat 10:
  - Response: err_len=1 and DRAIN (rstate=2) through beat 10.
  - Then send a good packet. Response: delivered, with no data from beats 8..10.
- Bad tkeep: beat 2 with tkeep=64'hFFFF_FFFF_0000_FFFF gives err_keep=1 while the packet is still delivered. clr clears err_keep and err_len.
- Mid-operation events:
  - m_axis_h2c_areset asserted after beat 4: all outputs return to reset values asynchronously.
  - clr coincident with beat 7 (with tlast): data_valid stays 0 and beat_cnt=0.

Source files
------------

// File: rtl/axi_h2c_read.sv
// XDMA H2C AXI4-Stream receiver: assembles BEATS 512-bit beats (first beat in the
// least-significant slice) into one wide word and hands it off via data_valid/data_next.
module axi_h2c_read #(
  parameter int unsigned BEATS = 8,
  parameter int unsigned DW    = 512
) (
  input  logic                  m_axis_h2c_aclk,
  input  logic                  m_axis_h2c_areset,
  input  logic                  clr,
  input  logic [DW-1:0]         m_axis_h2c_tdata,
  input  logic [DW/8-1:0]       m_axis_h2c_tkeep,
  input  logic                  m_axis_h2c_tlast,
  input  logic                  m_axis_h2c_tvalid,
  output logic                  m_axis_h2c_tready,
  output logic [BEATS*DW-1:0]   data,
  output logic                  data_valid,
  input  logic                  data_next,
  output logic [1:0]            rstate,
  output logic [4:0]            beat_cnt,
  output logic [15:0]           pkt_cnt,
  output logic                  err_len,
  output logic                  err_keep
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   at_last;
  logic   keep_bad;

  assign accept   = m_axis_h2c_tvalid & m_axis_h2c_tready;
  assign at_last  = (beat_cnt == 5'(BEATS - 1));
  assign keep_bad = accept & (m_axis_h2c_tkeep != '1);
  assign rstate   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (accept && at_last) begin
          state_nxt = m_axis_h2c_tlast ? HOLD : DRAIN;
        end
      end
      HOLD: begin
        if (data_next) begin
          state_nxt = COLLECT;
        end
      end
      DRAIN: begin
        if (accept && m_axis_h2c_tlast) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
    if (clr) begin
      state_nxt = COLLECT;
    end
  end

  // tready is a register loaded with the decode of the next state, so it is low
  // while reset is held and otherwise always equals the decode of the current state.
  always_ff @(posedge m_axis_h2c_aclk or posedge m_axis_h2c_areset) begin
    if (m_axis_h2c_areset) begin
      state             <= COLLECT;
      m_axis_h2c_tready <= 1'b0;
    end else begin
      state             <= state_nxt;
      m_axis_h2c_tready <= (state_nxt != HOLD);
    end
  end

  always_ff @(posedge m_axis_h2c_aclk or posedge m_axis_h2c_areset) begin
    if (m_axis_h2c_areset) begin
      data       <= '0;
      data_valid <= 1'b0;
      beat_cnt   <= '0;
      pkt_cnt    <= '0;
      err_len    <= 1'b0;
      err_keep   <= 1'b0;
    end else if (clr) begin
      data       <= '0;
      data_valid <= 1'b0;
      beat_cnt   <= '0;
      pkt_cnt    <= '0;
      err_len    <= 1'b0;
      err_keep   <= 1'b0;
    end else begin
      if (keep_bad) begin
        err_keep <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (accept) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
              if (beat_cnt == 5'(k)) begin
                data[k*DW +: DW] <= m_axis_h2c_tdata;
              end
            end
            if (at_last || m_axis_h2c_tlast) begin
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
            if (at_last && m_axis_h2c_tlast) begin
              data_valid <= 1'b1;
            end
            // Early tlast and missing tlast are both length errors.
            if (at_last != m_axis_h2c_tlast) begin
              err_len <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (data_next) begin
            data_valid <= 1'b0;
            pkt_cnt    <= pkt_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_h2c_read.sv
// Self-checking bench for axi_h2c_read: directed scenarios plus randomized packets
// compared against expected words built by the bench.
module tb_axi_h2c_read;

  localparam int unsigned BEATS = 8;
  localparam int unsigned DW    = 512;
  localparam logic [DW/8-1:0] BADKEEP = 64'hFFFF_FFFF_0000_FFFF;

  typedef logic [BEATS*DW-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clr = 1'b0;
  logic [DW-1:0]     tdata = '0;
  logic [DW/8-1:0]   tkeep = '1;
  logic              tlast = 1'b0;
  logic              tvalid = 1'b0;
  logic              tready;
  word_t             data;
  logic              data_valid;
  logic              data_next = 1'b0;
  logic [1:0]        rstate;
  logic [4:0]        beat_cnt;
  logic [15:0]       pkt_cnt;
  logic              err_len;
  logic              err_keep;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_h2c_read #(.BEATS(BEATS), .DW(DW)) dut (
    .m_axis_h2c_aclk   (clk),
    .m_axis_h2c_areset (rst),
    .clr               (clr),
    .m_axis_h2c_tdata  (tdata),
    .m_axis_h2c_tkeep  (tkeep),
    .m_axis_h2c_tlast  (tlast),
    .m_axis_h2c_tvalid (tvalid),
    .m_axis_h2c_tready (tready),
    .data              (data),
    .data_valid        (data_valid),
    .data_next         (data_next),
    .rstate            (rstate),
    .beat_cnt          (beat_cnt),
    .pkt_cnt           (pkt_cnt),
    .err_len           (err_len),
    .err_keep          (err_keep)
  );

  function automatic word_t pattern_word(input logic [7:0] base, input logic [7:0] step);
    word_t w;
    logic [7:0] b;
    for (int k = 0; k < BEATS; k++) begin
      b = base + step * 8'(k);
      w[k*DW +: DW] = {64{b}};
    end
    return w;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < BEATS*DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int first_diff(input word_t a, input word_t b);
    for (int k = 0; k < BEATS; k++)
      if (a[k*DW +: DW] !== b[k*DW +: DW]) return k;
    return -1;
  endfunction

  // Offers one beat and waits (bounded) until it is taken; leaves tvalid high.
  task automatic drive_beat(input logic [DW-1:0] d, input logic last,
                            input logic [DW/8-1:0] keep, output int acc_cyc);
    logic a;
    tdata = d; tlast = last; tkeep = keep; tvalid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); a = tready;
      @(posedge clk); #1;
      if (a) begin acc_cyc = cyc; break; end
    end
    if (acc_cyc < 0) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout got=no_accept exp=accept");
    end
  endtask

  task automatic send_packet(input word_t w, input int bad_beat, input int gap_max);
    int c;
    int g;
    for (int k = 0; k < BEATS; k++) begin
      drive_beat(w[k*DW +: DW], k == BEATS-1, (k == bad_beat) ? BADKEEP : '1, c);
      if (gap_max > 0 && k < BEATS-1) begin
        g = $urandom_range(gap_max, 0);
        if (g > 0) begin
          tvalid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
    end
    tvalid = 1'b0; tlast = 1'b0; tkeep = '1;
  endtask

  task automatic ack();
    data_next = 1'b1;
    @(posedge clk); #1;
    data_next = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; clr = 1'b0; data_next = 1'b0; tkeep = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({tready, data_valid, rstate, beat_cnt, pkt_cnt, err_len, err_keep} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b/%b/%0d/%0d/%0d/%b/%b exp=all_zero",
               tready, data_valid, rstate, beat_cnt, pkt_cnt, err_len, err_keep);
    end
    total++;
    if (data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", data[31:0]); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (tready !== 1'b1) begin bad++; $display("FAIL reset_tready_after got=%b exp=1", tready); end
  endtask

  task automatic test_nominal();
    word_t w;
    int c;
    do_reset();
    w = pattern_word(8'h00, 8'h01);
    for (int k = 0; k < BEATS; k++) begin
      drive_beat(w[k*DW +: DW], k == BEATS-1, '1, c);
      if (k == BEATS-2) begin
        total++;
        if (data_valid !== 1'b0 || beat_cnt !== 5'(BEATS-1)) begin
          bad++;
          $display("FAIL nom_pre_last got=valid%b cnt%0d exp=valid0 cnt%0d", data_valid, beat_cnt, BEATS-1);
        end
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
    total++;
    if (data_valid !== 1'b1 || tready !== 1'b0 || rstate !== 2'd1 || beat_cnt !== 5'd0) begin
      bad++;
      $display("FAIL nom_hold got=valid%b rdy%b st%0d cnt%0d exp=valid1 rdy0 st1 cnt0",
               data_valid, tready, rstate, beat_cnt);
    end
    total++;
    if (data !== w) begin
      bad++;
      $display("FAIL nom_data beat=%0d got=%h exp=%h", first_diff(data, w), data[31:0], w[31:0]);
    end
    ack();
    total++;
    if (data_valid !== 1'b0 || pkt_cnt !== 16'd1 || tready !== 1'b1) begin
      bad++;
      $display("FAIL nom_ack got=valid%b pkt%0d rdy%b exp=valid0 pkt1 rdy1", data_valid, pkt_cnt, tready);
    end
  endtask

  task automatic test_backpressure();
    word_t w, w2;
    do_reset();
    w = rand_word();
    send_packet(w, -1, 0);
    tdata = {16{$urandom}}; tlast = 1'b0; tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (tready !== 1'b0 || data_valid !== 1'b1 || data !== w) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=rdy%b valid%b d%h exp=rdy0 valid1 d%h",
                 i, tready, data_valid, data[31:0], w[31:0]);
      end
    end
    tvalid = 1'b0;
    total++;
    if (beat_cnt !== 5'd0) begin bad++; $display("FAIL bp_no_accept got=%0d exp=0", beat_cnt); end
    ack();
    w2 = rand_word();
    send_packet(w2, -1, 2);
    total++;
    if (data_valid !== 1'b1 || data !== w2 || pkt_cnt !== 16'd1) begin
      bad++;
      $display("FAIL bp_second got=valid%b pkt%0d beat=%0d exp=valid1 pkt1 beat=-1",
               data_valid, pkt_cnt, first_diff(data, w2));
    end
    ack();
  endtask

  task automatic test_early_tlast();
    word_t w;
    int c;
    do_reset();
    for (int k = 0; k < 4; k++) drive_beat({64{8'(k)}}, k == 3, '1, c);
    tvalid = 1'b0; tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (err_len !== 1'b1 || data_valid !== 1'b0 || beat_cnt !== 5'd0 || rstate !== 2'd0) begin
      bad++;
      $display("FAIL early_err got=err%b valid%b cnt%0d st%0d exp=err1 valid0 cnt0 st0",
               err_len, data_valid, beat_cnt, rstate);
    end
    w = pattern_word(8'hA5, 8'h00);
    send_packet(w, -1, 0);
    total++;
    if (data_valid !== 1'b1 || data !== w) begin
      bad++;
      $display("FAIL early_next got=valid%b beat=%0d exp=valid1 beat=-1", data_valid, first_diff(data, w));
    end
    ack();
    total++;
    if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL early_pkt got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic test_missing_tlast();
    word_t w;
    int c;
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      drive_beat((k < 8) ? {64{8'(k)}} : {64{8'hEE}}, k == 10, '1, c);
      if (k == 7) begin
        total++;
        if (rstate !== 2'd2 || err_len !== 1'b1 || beat_cnt !== 5'd0) begin
          bad++;
          $display("FAIL miss_drain got=st%0d err%b cnt%0d exp=st2 err1 cnt0", rstate, err_len, beat_cnt);
        end
      end else if (k > 7) begin
        total++;
        if (rstate !== ((k == 10) ? 2'd0 : 2'd2)) begin
          bad++;
          $display("FAIL miss_state beat=%0d got=%0d exp=%0d", k, rstate, (k == 10) ? 0 : 2);
        end
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
    w = pattern_word(8'h10, 8'h01);
    send_packet(w, -1, 1);
    total++;
    if (data_valid !== 1'b1 || data !== w) begin
      bad++;
      $display("FAIL miss_next got=valid%b beat=%0d exp=valid1 beat=-1", data_valid, first_diff(data, w));
    end
    ack();
    total++;
    if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL miss_pkt got=%0d exp=1", pkt_cnt); end
  endtask

  task automatic test_bad_keep();
    word_t w;
    int c;
    do_reset();
    drive_beat('0, 1'b0, '1, c);
    drive_beat('0, 1'b1, '1, c);
    tvalid = 1'b0; tlast = 1'b0;
    w = rand_word();
    send_packet(w, 2, 0);
    total++;
    if (err_keep !== 1'b1 || err_len !== 1'b1 || data_valid !== 1'b1 || data !== w) begin
      bad++;
      $display("FAIL keep_flag got=ek%b el%b valid%b beat=%0d exp=ek1 el1 valid1 beat=-1",
               err_keep, err_len, data_valid, first_diff(data, w));
    end
    ack();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if (err_keep !== 1'b0 || err_len !== 1'b0 || pkt_cnt !== 16'd0) begin
      bad++;
      $display("FAIL keep_clr got=ek%b el%b pkt%0d exp=ek0 el0 pkt0", err_keep, err_len, pkt_cnt);
    end
  endtask

  task automatic test_async_reset();
    word_t w;
    int c;
    do_reset();
    w = rand_word();
    send_packet(w, -1, 0);
    ack();
    for (int k = 0; k < 5; k++) drive_beat({64{8'(k)}}, 1'b0, '1, c);
    total++;
    if (beat_cnt !== 5'd5 || pkt_cnt !== 16'd1) begin
      bad++;
      $display("FAIL arst_pre got=cnt%0d pkt%0d exp=cnt5 pkt1", beat_cnt, pkt_cnt);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if ({tready, data_valid, rstate, beat_cnt, pkt_cnt, err_len, err_keep} !== '0 || data !== '0) begin
      bad++;
      $display("FAIL arst_now got=rdy%b cnt%0d pkt%0d st%0d d%h exp=all_zero",
               tready, beat_cnt, pkt_cnt, rstate, data[31:0]);
    end
    tvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (tready !== 1'b1 || beat_cnt !== 5'd0) begin
      bad++;
      $display("FAIL arst_after got=rdy%b cnt%0d exp=rdy1 cnt0", tready, beat_cnt);
    end
  endtask

  task automatic test_clr_beat();
    int c;
    do_reset();
    for (int k = 0; k < BEATS-1; k++) drive_beat({64{8'(k + 1)}}, 1'b0, '1, c);
    tdata = {64{8'h77}}; tlast = 1'b1; tvalid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    total++;
    if (data_valid !== 1'b0 || beat_cnt !== 5'd0 || rstate !== 2'd0 || tready !== 1'b1 || data !== '0) begin
      bad++;
      $display("FAIL clr_beat got=valid%b cnt%0d st%0d rdy%b d%h exp=valid0 cnt0 st0 rdy1 d0",
               data_valid, beat_cnt, rstate, tready, data[31:0]);
    end
    @(posedge clk); #1;
    total++;
    if (data_valid !== 1'b0) begin bad++; $display("FAIL clr_beat_later got=%b exp=0", data_valid); end
  endtask

  task automatic test_back_to_back();
    word_t w1, w2;
    int c, c0, c1;
    do_reset();
    data_next = 1'b1;
    w1 = rand_word();
    w2 = rand_word();
    c0 = -1; c1 = -1;
    for (int k = 0; k < BEATS; k++) begin
      drive_beat(w1[k*DW +: DW], k == BEATS-1, '1, c);
      if (k == 0) c0 = c;
    end
    total++;
    if (data_valid !== 1'b1 || data !== w1) begin
      bad++;
      $display("FAIL b2b_first got=valid%b beat=%0d exp=valid1 beat=-1", data_valid, first_diff(data, w1));
    end
    for (int k = 0; k < BEATS; k++) begin
      drive_beat(w2[k*DW +: DW], k == BEATS-1, '1, c);
      if (k == 0) c1 = c;
    end
    tvalid = 1'b0; tlast = 1'b0;
    total++;
    if (c1 - c0 !== BEATS + 1) begin
      bad++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", c1 - c0, BEATS + 1);
    end
    total++;
    if (data_valid !== 1'b1 || data !== w2) begin
      bad++;
      $display("FAIL b2b_second got=valid%b beat=%0d exp=valid1 beat=-1", data_valid, first_diff(data, w2));
    end
    @(posedge clk); #1;
    data_next = 1'b0;
    total++;
    if (pkt_cnt !== 16'd2 || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_pkt got=pkt%0d valid%b exp=pkt2 valid0", pkt_cnt, data_valid);
    end
  endtask

  task automatic test_random();
    word_t w;
    int bk, d;
    logic exp_keep;
    int exp_pkt;
    do_reset();
    exp_keep = 1'b0;
    exp_pkt = 0;
    for (int p = 0; p < 12; p++) begin
      w = rand_word();
      bk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(BEATS-1, 0)) : -1;
      if (bk >= 0) exp_keep = 1'b1;
      send_packet(w, bk, 2);
      total++;
      if (data_valid !== 1'b1 || data !== w || err_keep !== exp_keep || err_len !== 1'b0) begin
        bad++;
        $display("FAIL rnd_pkt p=%0d got=valid%b beat=%0d ek%b el%b exp=valid1 beat=-1 ek%b el0",
                 p, data_valid, first_diff(data, w), err_keep, err_len, exp_keep);
      end
      d = $urandom_range(4, 0);
      tdata = {16{$urandom}}; tvalid = 1'b1;
      repeat (d) begin @(posedge clk); #1; end
      tvalid = 1'b0;
      total++;
      if (beat_cnt !== 5'd0 || data !== w) begin
        bad++;
        $display("FAIL rnd_stall p=%0d got=cnt%0d beat=%0d exp=cnt0 beat=-1", p, beat_cnt, first_diff(data, w));
      end
      ack();
      exp_pkt++;
      total++;
      if (pkt_cnt !== 16'(exp_pkt) || data_valid !== 1'b0) begin
        bad++;
        $display("FAIL rnd_ack p=%0d got=pkt%0d valid%b exp=pkt%0d valid0", p, pkt_cnt, data_valid, exp_pkt);
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_tlast();
    test_missing_tlast();
    test_bad_keep();
    test_async_reset();
    test_clr_beat();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
